dmem_be_ctrl: RTL and testbench

- Parametrised data memory for the RISC-V core, replacing the fixed 8 KB word-only RAM.
- Adds byte and halfword stores via byte lanes, sign/zero-extended loads, and a configurable base address, depth and read latency.
- Uses a single-outstanding valid/ready request port with a one-cycle response pulse and misalignment error reporting.
- Sits between the core's load/store unit and the memory-mapped region decoder.

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_be_ctrl_if.sv | 18 +
 rtl/dmem_be_ram.sv | 42 ++++
 rtl/dmem_be_ctrl.sv | 98 +++++++++
 tb/tb_dmem_be_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-enable data memory.
// Provides the access size and FSM enums, lane-enable generation and load extension.
package dmem_pkg;

   typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10} size_e;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   // Encoding 2'b11 is not a real size; it behaves exactly like a word access.
   function automatic size_e norm_size(logic [1:0] s);
      return (s == 2'b11) ? SZ_W : size_e'(s);
   endfunction

   function automatic logic [3:0] be_from_size(size_e size, logic [1:0] offset);
      case (size)
         SZ_B:    return 4'b0001 << offset;
         SZ_H:    return offset[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(logic [31:0] word, size_e size,
                                               logic [1:0] offset, logic is_unsigned);
      logic [31:0] sh;
      sh = word >> {offset, 3'b000};
      case (size)
         SZ_B:    return {{24{~is_unsigned & sh[7]}}, sh[7:0]};
         SZ_H:    return {{16{~is_unsigned & sh[15]}}, sh[15:0]};
         default: return word;
      endcase
   endfunction

endpackage

// File: rtl/dmem_be_ctrl_if.sv
// Request/response bundle between the load/store unit (master) and the data memory (slave).
interface dmem_be_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
                   input  req_ready, rsp_valid, rsp_rdata, rsp_err);
   modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
                   output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/dmem_be_ram.sv
// DEPTH x 32 RAM with four byte-enable write lanes, synchronous read and optional output register.
// SIMULATION: zero-initialised array; otherwise the vendor byte-enable RAM inference template.
module dmem_be_ram #(
   parameter  int DEPTH    = 2048,
   parameter  int READ_LAT = 1,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          en,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

`ifdef SIMULATION
   logic [31:0] mem [DEPTH] = '{default: '0};
`else
   logic [31:0] mem [DEPTH];
`endif
   logic [31:0] rd_q;

   // Read-before-write; a single request never reads and writes in the same access.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         rd_q <= mem[addr];
      end
   end

   generate
      if (READ_LAT == 2) begin : g_oreg
         logic [31:0] rd_q2;
         always_ff @(posedge clk) rd_q2 <= rd_q;
         assign rdata = rd_q2;
      end else begin : g_noreg
         assign rdata = rd_q;
      end
   endgenerate

endmodule

// File: rtl/dmem_be_ctrl.sv
// Single-outstanding data memory controller: byte/half/word stores, extended loads, misalign errors.
// Optional DMEM_BOUNDS_EN rejects addresses outside [BASE_ADDR, BASE_ADDR+4*DEPTH).
module dmem_be_ctrl
   import dmem_pkg::*;
#(
   parameter int          DEPTH     = 2048,
   parameter int          READ_LAT  = 1,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input logic           clk,
   input logic           reset,
   dmem_be_ctrl_if.slave bus
);

   localparam int AW = $clog2(DEPTH);

   state_e        state, nxt;
   size_e         sz, sz_q;
   logic          accept, err, err_q, we_q, uns_q;
   logic [1:0]    off_q;
   logic [31:0]   rel, wdata_lanes, ram_rdata;
   logic [3:0]    be;
   logic [AW-1:0] idx;

   assign sz     = norm_size(bus.req_size);
   assign rel    = bus.req_addr - BASE_ADDR;
   assign idx    = AW'(rel >> 2);
   assign accept = bus.req_valid & bus.req_ready;

   // BASE_ADDR is aligned, so rel[1:0] equals the address lane offset.
   always_comb begin
      err = (sz == SZ_H && rel[0]) || (sz == SZ_W && rel[1:0] != 2'b00);
`ifdef DMEM_BOUNDS_EN
      err = err || (rel >= 32'(4 * DEPTH));
`endif
   end

   always_comb begin
      case (sz)
         SZ_B:    wdata_lanes = {4{bus.req_wdata[7:0]}};
         SZ_H:    wdata_lanes = {2{bus.req_wdata[15:0]}};
         default: wdata_lanes = bus.req_wdata;
      endcase
   end

   assign be = (accept && bus.req_we && !err) ? be_from_size(sz, rel[1:0]) : 4'b0000;

   dmem_be_ram #(.DEPTH(DEPTH), .READ_LAT(READ_LAT)) u_ram (
      .clk  (clk),
      .en   (accept),
      .be   (be),
      .addr (idx),
      .wdata(wdata_lanes),
      .rdata(ram_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
         we_q  <= 1'b0;
         uns_q <= 1'b0;
         sz_q  <= SZ_B;
         off_q <= 2'b00;
      end else if (accept) begin
         err_q <= err;
         we_q  <= bus.req_we;
         uns_q <= bus.req_unsigned;
         sz_q  <= sz;
         off_q <= rel[1:0];
      end
   end

   assign bus.req_ready = (state == IDLE) && !reset;

   always_comb begin
      nxt           = state;
      bus.rsp_valid = 1'b0;
      bus.rsp_err   = 1'b0;
      bus.rsp_rdata = '0;
      case (state)
         IDLE: if (accept) nxt = (!bus.req_we && !err && READ_LAT == 2) ? WAIT : RESP;
         WAIT: nxt = RESP;
         RESP: begin
            nxt           = IDLE;
            bus.rsp_valid = 1'b1;
            bus.rsp_err   = err_q;
            if (!err_q && !we_q) bus.rsp_rdata = load_extend(ram_rdata, sz_q, off_q, uns_q);
         end
         default: nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dmem_be_ctrl.sv
// Randomised self-checking bench: READ_LAT=1 and READ_LAT=2 instances against a byte-addressed model.
module tb_dmem_be_ctrl;

   localparam int DEPTH = 2048;
   localparam int NB    = 4 * DEPTH;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        rq_valid = 1'b0, rq_we = 1'b0, rq_uns = 1'b0;
   logic [31:0] rq_addr = '0, rq_wdata = '0;
   logic [1:0]  rq_size = '0;

   dmem_be_ctrl_if if1 ();
   dmem_be_ctrl_if if2 ();

   assign if1.req_valid = rq_valid;  assign if2.req_valid = rq_valid;
   assign if1.req_we = rq_we;        assign if2.req_we = rq_we;
   assign if1.req_addr = rq_addr;    assign if2.req_addr = rq_addr;
   assign if1.req_wdata = rq_wdata;  assign if2.req_wdata = rq_wdata;
   assign if1.req_size = rq_size;    assign if2.req_size = rq_size;
   assign if1.req_unsigned = rq_uns; assign if2.req_unsigned = rq_uns;

   dmem_be_ctrl #(.DEPTH(DEPTH), .READ_LAT(1), .BASE_ADDR(32'h0)) u_dut1 (
      .clk(clk), .reset(rst), .bus(if1));
   dmem_be_ctrl #(.DEPTH(DEPTH), .READ_LAT(2), .BASE_ADDR(32'h0)) u_dut2 (
      .clk(clk), .reset(rst), .bus(if2));

   typedef struct {int due; logic err; logic [31:0] data;} exp_t;
   exp_t        qs [2][$];
   logic [7:0]  mb [NB];
   int          cyc = 0;
   int          nerr = 0, nchk = 0;
   logic [31:0] lrd [2];
   logic        ler [2];
   bit          got [2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      nchk++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Model: byte-addressed memory, little-endian, wrapping modulo NB.
   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic mdl_err(input logic [31:0] a, input logic [1:0] sz);
      logic e;
      e = (nbytes(sz) == 2 && a[0]) || (nbytes(sz) == 4 && a[1:0] != 2'b00);
`ifdef DMEM_BOUNDS_EN
      if (a >= NB) e = 1'b1;
`endif
      return e;
   endfunction

   function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
      logic [31:0] v;
      int n;
      n = nbytes(sz);
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mb[int'((a + 32'(i)) % NB)];
      if (!u && n < 4 && v[8*n-1])
         for (int j = 8*n; j < 32; j++) v[j] = 1'b1;
      return v;
   endfunction

   // One compare process: every cycle, each DUT either owes a response now or must be silent.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         logic        v, e, rdy;
         logic [31:0] r;
         v   = d ? if2.rsp_valid : if1.rsp_valid;
         e   = d ? if2.rsp_err   : if1.rsp_err;
         r   = d ? if2.rsp_rdata : if1.rsp_rdata;
         rdy = d ? if2.req_ready : if1.req_ready;
         if (rst) begin
            chk($sformatf("rst_valid%0d", d), {31'b0, v}, 32'd0);
            chk($sformatf("rst_ready%0d", d), {31'b0, rdy}, 32'd0);
            chk($sformatf("rst_rdata%0d", d), r, 32'd0);
         end else if (qs[d].size() > 0 && qs[d][0].due == cyc) begin
            chk($sformatf("rsp_valid%0d", d), {31'b0, v}, 32'd1);
            chk($sformatf("rsp_err%0d", d), {31'b0, e}, {31'b0, qs[d][0].err});
            chk($sformatf("rsp_rdata%0d", d), r, qs[d][0].data);
            lrd[d] = r; ler[d] = e; got[d] = 1'b1;
            void'(qs[d].pop_front());
         end else begin
            chk($sformatf("idle_valid%0d", d), {31'b0, v}, 32'd0);
         end
      end
   end

   task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic u, input bit mid_rst);
      exp_t x;
      int   w;
      logic e;
      w = 0;
      while (!(if1.req_ready && if2.req_ready) && w < 10) begin
         @(posedge clk); #1; w++;
      end
      if (w >= 10) begin
         nchk++; nerr++;
         $display("FAIL ready_timeout: got not-ready expected ready within 10 cycles");
      end
      rq_valid = 1'b1; rq_we = we; rq_addr = a; rq_wdata = wd; rq_size = sz; rq_uns = u;
      e = mdl_err(a, sz);
      x.err  = e;
      x.data = (!we && !e) ? mdl_load(a, sz, u) : 32'd0;
      for (int d = 0; d < 2; d++) begin
         x.due  = cyc + ((we || e) ? 1 : d + 1);
         qs[d].push_back(x);
         got[d] = 1'b0;
      end
      @(posedge clk); #1;
      if (we && !e)
         for (int i = 0; i < nbytes(sz); i++) mb[int'((a + 32'(i)) % NB)] = wd[8*i +: 8];
      if (mid_rst) begin
         rst = 1'b1;
         qs[0].delete(); qs[1].delete();
         rq_valid = 1'b0;
      end else begin
         // Busy-cycle junk must be ignored.
         rq_we = 1'($urandom); rq_addr = $urandom_range(0, 255);
         rq_wdata = $urandom; rq_size = 2'($urandom);
      end
      @(posedge clk); #1;
      rq_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic dir_chk(input string nm, input logic [31:0] req_d, input logic req_e);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s_got%0d", nm, d), {31'b0, got[d]}, 32'd1);
         chk($sformatf("%s_data%0d", nm, d), lrd[d], req_d);
         chk($sformatf("%s_err%0d", nm, d), {31'b0, ler[d]}, {31'b0, req_e});
      end
   endtask

   initial begin
      logic [31:0] a;
      logic [1:0]  sz;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("ready_after_reset1", {31'b0, if1.req_ready}, 32'd1);
      chk("ready_after_reset2", {31'b0, if2.req_ready}, 32'd1);
      @(posedge clk); #1;

      for (int i = 0; i < 256; i += 4) issue(1'b1, 32'(i), 32'hA500_0000 | 32'(i), 2'd2, 1'b0, 1'b0);

      issue(1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, 1'b0);  dir_chk("st_w", 32'h0, 1'b0);
      issue(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b0);          dir_chk("ld_w", 32'hDEAD_BEEF, 1'b0);
      issue(1'b1, 32'h12, 32'h0000_005A, 2'd0, 1'b0, 1'b0);
      issue(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b0);          dir_chk("ld_w2", 32'hDE5A_BEEF, 1'b0);
      issue(1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 1'b0);          dir_chk("ld_bs", 32'hFFFF_FFDE, 1'b0);
      issue(1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 1'b0);          dir_chk("ld_bu", 32'h0000_00DE, 1'b0);
      issue(1'b1, 32'h16, 32'h0000_8001, 2'd1, 1'b0, 1'b0);
      issue(1'b0, 32'h16, 32'h0, 2'd1, 1'b0, 1'b0);          dir_chk("ld_hs", 32'hFFFF_8001, 1'b0);
      issue(1'b0, 32'h16, 32'h0, 2'd1, 1'b1, 1'b0);          dir_chk("ld_hu", 32'h0000_8001, 1'b0);
      issue(1'b0, 32'h14, 32'h0, 2'd2, 1'b0, 1'b0);          dir_chk("ld_w14", 32'h8001_0014, 1'b0);
      issue(1'b1, 32'h21, 32'h1234_5678, 2'd2, 1'b0, 1'b0);  dir_chk("st_mis", 32'h0, 1'b1);
      issue(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 1'b0);          dir_chk("ld_w20", 32'hA500_0020, 1'b0);
      issue(1'b0, 32'h23, 32'h0, 2'd1, 1'b0, 1'b0);          dir_chk("ld_hmis", 32'h0, 1'b1);
      issue(1'b0, 32'h2010, 32'h0, 2'd2, 1'b0, 1'b0);
`ifdef DMEM_BOUNDS_EN
      dir_chk("ld_oob", 32'h0, 1'b1);
`else
      dir_chk("ld_wrap", 32'hDE5A_BEEF, 1'b0);
`endif

      // Reset while the READ_LAT=2 instance sits in WAIT: the load must vanish.
      issue(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b1);
      rst = 1'b0;
      #1;
      chk("ready_release1", {31'b0, if1.req_ready}, 32'd1);
      chk("ready_release2", {31'b0, if2.req_ready}, 32'd1);
      for (int d = 0; d < 2; d++) chk($sformatf("no_rsp_in_reset%0d", d), {31'b0, got[d]}, 32'd0);
      @(posedge clk); #1;
      issue(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b0);          dir_chk("ld_after_rst", 32'hDE5A_BEEF, 1'b0);

      for (int it = 0; it < 300; it++) begin
         sz = 2'($urandom);
         a  = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 1) a = a & ~32'(nbytes(sz) - 1);
         if ($urandom_range(0, 3) == 0) a = a + (32'($urandom_range(1, 3)) << 13);
         issue(1'($urandom_range(0, 2) == 0), a, $urandom, sz, 1'($urandom), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
